multi_stream_sync: RTL and testbench
====================================

# multi_stream_sync

Parametrised N-channel packet aligner for byte/word streams. Each channel captures one packet into its own single-port buffer. Once every enabled channel has closed its packet, all channels replay in lockstep under per-beat valid/ready handshakes. Optional padding equalises packet lengths so that all sinks assert last on the same beat. The block sits between independent capture sources and downstream consumers that need time-aligned packets.

## Interface
- CH, 2: number of channels (≥1)
- DATA_W, 8: beat width in bits
- DEPTH, 256: buffer depth per channel in beats (power of two); ADDR_W = log2(DEPTH)
- PAD_MODE, 0: 0 = each channel replays its own length; 1 = all channels replay max length, padded
- PAD_VAL, 0: DATA_W-bit fill value used in PAD_MODE=1
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-low
- ch_en  in  CH  channel enable; change only in CAPTURE before any beat is accepted
- src_valid  in  CH  per-channel input beat valid
- src_data  in  CH*DATA_W  input beats, channel i at [i*DATA_W +: DATA_W]
- src_last  in  CH  final beat of the input packet
- src_ready  out  CH  channel accepts a beat
- sink_data  out  CH*DATA_W  output beats, same packing as src_data
- sink_valid  out  CH  output beat valid
- sink_last  out  CH  final output beat of the channel
- sink_ready  in  CH  downstream accepts a beat
- overflow  out  CH  sticky: channel packet truncated at DEPTH beats
- busy  out  1  high in LOAD/PLAY

## Operation
- FSM states: CAPTURE, LOAD, PLAY. Reset enters CAPTURE.
- CAPTURE behaviour:
  - src_ready[i] = rst & CAPTURE & ch_en[i] & ~closed[i] (combinational from registers).
  - Accept on src_valid & src_ready; write to buffer[i] at wr_ptr[i]; increment wr_ptr[i].
  - An accepted src_last sets closed[i] and len[i] = wr_ptr+1. len is ADDR_W+1 bits.
- Overflow: an accepted beat at wr_ptr = DEPTH-1 without src_last is treated as last. It sets closed[i], sets len = DEPTH, and sets overflow[i]. Overflow is cleared only by reset.
- Disabled channels count as closed with len 0. If all channels are disabled, the block stays in CAPTURE.
- CAPTURE -> LOAD: in the cycle where all channels are closed, including a closing beat accepted that same cycle, provided at least one channel is enabled.
- LOAD: present read address 0 to every buffer, taking one cycle. Then go to PLAY. Set tgt[i] = len[i] in mode 0, or tgt[i] = max(len) for enabled channels in mode 1.
- PLAY:
  - sink_valid[i] = (rd_cnt[i] < tgt[i]).
  - sink_data[i] comes from the buffer read register. If rd_cnt ≥ len[i] (mode 1), it is PAD_VAL instead.
  - sink_last[i] = sink_valid[i] & (rd_cnt[i] = tgt[i]-1).
- Lockstep rule: fire = PLAY & every channel with sink_valid=1 has sink_ready=1. On fire, every valid channel increments rd_cnt, and the read address becomes rd_cnt+1 the same cycle.
- A channel with sink_valid=0 (finished in mode 0, or disabled) never blocks fire.
- PLAY -> CAPTURE: on the fire in which no channel remains valid afterwards. That transition clears closed, wr_ptr, rd_cnt and len. overflow is not cleared.
- Inputs are ignored outside CAPTURE: src_ready=0, so there is no overlap of capture and replay.

## Timing
- Reset values: src_ready=0, sink_valid=0, sink_last=0, sink_data=0, overflow=0, busy=0.
- src_ready rises in the first cycle with rst=1.
- A closing beat accepted in cycle c gives LOAD in c+1. PLAY starts in c+2 with sink_valid=1 and beat 0 on sink_data.
- Throughput in PLAY is one beat per cycle while all valid sinks are ready. Holding any valid sink_ready low stalls all channels, and data/valid/last hold stable.
- After the final fire in cycle p, src_ready is high in p+1.
- In mode 0, channels with shorter packets drop valid early. In mode 1, all enabled sink_last assert in the same cycle.
- Reset mid-operation (rst low at any edge) returns to CAPTURE and discards the partial packet and the buffered data.

## Test plan
- Directed, CH=2, mode 0, all ready=1:
  - Stimulus: ch0 gets 4 beats 0x10..0x13 with last; ch1 gets 2 beats 0xA0,0xA1 later.
  - Response: PLAY starts 2 cycles after the ch1 last. ch0 emits 0x10..0x13 with last on 0x13. ch1 emits 0xA0,0xA1 with last on 0xA1 in cycle 2 of PLAY. Then src_ready=11.
- Mode 1, same stimulus:
  - ch1 emits 0xA0,0xA1,PAD,PAD.
  - Both sink_last are high in PLAY cycle 4.
- Backpressure: during replay, sink_ready[1]=0 for 3 cycles mid-packet.
  - Neither channel advances and outputs stay stable.
  - Replay resumes with no lost or duplicated beats.
- Overflow with DEPTH=8: feed 10 beats on ch0, no last.
  - src_ready[0] drops after the 8th beat and overflow[0]=1.
  - Replay gives 8 beats with last on the 8th.
  - overflow[0] stays 1 after the next packet.
- ch_en=01: only ch0 captures.
  - ch1 src_ready=0 and sink_valid=0 throughout.
  - Replay starts after the ch0 last alone.
- Reset: rst=0 for 1 cycle during PLAY beat 2.
  - All outputs are 0 at the next edge.
  - A fresh packet then replays correctly.

Source files
------------

// File: rtl/multi_stream_sync_if.sv
// multi_stream_sync_if: capture/replay stream bundle for multi_stream_sync.
interface multi_stream_sync_if #(
    parameter int CH = 2,
    parameter int DATA_W = 8
);
    logic [CH-1:0]        ch_en;
    logic [CH-1:0]        src_valid;
    logic [CH-1:0]        src_last;
    logic [CH-1:0]        src_ready;
    logic [CH*DATA_W-1:0] src_data;
    logic [CH-1:0]        sink_valid;
    logic [CH-1:0]        sink_last;
    logic [CH-1:0]        sink_ready;
    logic [CH*DATA_W-1:0] sink_data;
    logic [CH-1:0]        overflow;
    logic                 busy;

    modport master (
        output ch_en, src_valid, src_data, src_last, sink_ready,
        input  src_ready, sink_data, sink_valid, sink_last, overflow, busy
    );
    modport slave (
        input  ch_en, src_valid, src_data, src_last, sink_ready,
        output src_ready, sink_data, sink_valid, sink_last, overflow, busy
    );
endinterface

// File: rtl/multi_stream_sync.sv
// multi_stream_sync: captures one packet per channel, then replays all channels
// in lockstep, optionally padding every channel to the longest packet.
module multi_stream_sync #(
    parameter int                CH       = 2,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 256,
    parameter int                PAD_MODE = 0,
    parameter logic [DATA_W-1:0] PAD_VAL  = '0
) (
    input logic                clk,
    input logic                rst,
    multi_stream_sync_if.slave io_if
);
    localparam int ADDR_W = $clog2(DEPTH);
    typedef enum logic [1:0] {CAPTURE, LOAD, PLAY} state_t;

    state_t              r_state, w_state_nx;
    logic [ADDR_W-1:0]   r_wr_ptr [CH];
    logic [ADDR_W:0]     r_len    [CH];
    logic [ADDR_W:0]     r_tgt    [CH];
    logic [ADDR_W:0]     r_rd_cnt [CH];
    logic [CH-1:0]       r_closed, r_overflow;
    logic [CH-1:0]       w_acc, w_close, w_valid, w_more;
    logic [ADDR_W-1:0]   w_rd_addr [CH];
    logic [ADDR_W:0]     w_max_len;
    logic                w_fire, w_all_closed, w_done;

    assign io_if.src_ready = {CH{rst & (r_state == CAPTURE)}} & io_if.ch_en & ~r_closed;
    assign io_if.sink_valid = w_valid;
    assign io_if.overflow = r_overflow;
    assign io_if.busy = r_state != CAPTURE;
    assign w_fire = (r_state == PLAY) & (&(~w_valid | io_if.sink_ready));
    assign w_all_closed = &(r_closed | w_close | ~io_if.ch_en);
    assign w_done = w_fire & ~(|w_more);

    // The beat at the last buffer slot closes the packet even without src_last.
    always_comb begin
        w_max_len = '0;
        for (int k = 0; k < CH; k++) begin
            w_acc[k] = io_if.src_valid[k] & io_if.src_ready[k];
            w_close[k] = w_acc[k] & (io_if.src_last[k] | (&r_wr_ptr[k]));
            w_valid[k] = (r_state == PLAY) & (r_rd_cnt[k] < r_tgt[k]);
            w_more[k] = w_valid[k] & (r_rd_cnt[k] + (ADDR_W+1)'(1) < r_tgt[k]);
            io_if.sink_last[k] = w_valid[k] & (r_rd_cnt[k] + (ADDR_W+1)'(1) == r_tgt[k]);
            if (io_if.ch_en[k] && r_len[k] > w_max_len) w_max_len = r_len[k];
        end
    end

    // Read address runs one beat ahead on fire so the read register is ready next cycle.
    always_comb begin
        for (int k = 0; k < CH; k++)
            w_rd_addr[k] = (w_fire && w_valid[k]) ? r_rd_cnt[k][ADDR_W-1:0] + ADDR_W'(1)
                                                  : r_rd_cnt[k][ADDR_W-1:0];
    end

    always_comb begin
        w_state_nx = r_state;
        w_state_nx = (r_state == CAPTURE) ? ((w_all_closed && |io_if.ch_en) ? LOAD : CAPTURE) :
                     (r_state == LOAD)    ? PLAY :
                     (w_done ? CAPTURE : PLAY);
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= CAPTURE;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_closed   <= '0;
            r_overflow <= '0;
            for (int k = 0; k < CH; k++) begin
                r_wr_ptr[k] <= '0;
                r_len[k]    <= '0;
                r_tgt[k]    <= '0;
                r_rd_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (w_acc[k]) r_wr_ptr[k] <= r_wr_ptr[k] + ADDR_W'(1);
                if (w_close[k]) begin
                    r_closed[k] <= 1'b1;
                    r_len[k]    <= {1'b0, r_wr_ptr[k]} + (ADDR_W+1)'(1);
                end
                if (w_acc[k] && (&r_wr_ptr[k]) && !io_if.src_last[k]) r_overflow[k] <= 1'b1;
                if (r_state == LOAD)
                    r_tgt[k] <= (PAD_MODE != 0) ? (io_if.ch_en[k] ? w_max_len : '0) : r_len[k];
                if (w_fire && w_valid[k]) r_rd_cnt[k] <= r_rd_cnt[k] + (ADDR_W+1)'(1);
                if (w_done) begin
                    r_closed[k] <= 1'b0;
                    r_wr_ptr[k] <= '0;
                    r_len[k]    <= '0;
                    r_rd_cnt[k] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_rd_data;
        always_ff @(posedge clk) begin
            if (w_acc[g]) r_mem[r_wr_ptr[g]] <= io_if.src_data[g*DATA_W +: DATA_W];
            r_rd_data <= r_mem[w_rd_addr[g]];
        end
        assign io_if.sink_data[g*DATA_W +: DATA_W] =
            !w_valid[g] ? '0 : (r_rd_cnt[g] >= r_len[g]) ? PAD_VAL : r_rd_data;
    end
endmodule

// File: tb/tb_multi_stream_sync.sv
// tb_multi_stream_sync: randomized scoreboard bench; mode-0 and mode-1 instances
// share stimulus, and the one selected by sel is observed.
module tb_multi_stream_sync;
    localparam int CH = 2, DW = 8, DEPTH = 8;
    localparam logic [7:0] PAD = 8'hEE;
    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [15:0] d;
        bit          fin;
    } rec_t;

    logic        clk = 0, rst = 0, sel = 0;
    logic [1:0]  ch_en = 2'b11, src_valid = 0, src_last = 0, sink_ready = 0;
    logic [15:0] src_data = 0;
    logic [1:0]  m_src_ready, m_sink_valid, m_sink_last, m_overflow;
    logic [15:0] m_sink_data;
    logic        m_busy;
    int          total = 0, bad = 0, cyc = 0, pops = 0, exp_first = 0;
    bit          await_first = 0, chk_sr = 0, rdy_rand = 0;
    logic [1:0]  rdy_force = 2'b11, ovf_model = 0;
    rec_t        sb[$];

    multi_stream_sync_if #(.CH(CH), .DATA_W(DW)) bus0 ();
    multi_stream_sync_if #(.CH(CH), .DATA_W(DW)) bus1 ();

    assign bus0.ch_en = ch_en;         assign bus1.ch_en = ch_en;
    assign bus0.src_valid = src_valid; assign bus1.src_valid = src_valid;
    assign bus0.src_data = src_data;   assign bus1.src_data = src_data;
    assign bus0.src_last = src_last;   assign bus1.src_last = src_last;
    assign bus0.sink_ready = sink_ready; assign bus1.sink_ready = sink_ready;

    assign m_src_ready  = sel ? bus1.src_ready  : bus0.src_ready;
    assign m_sink_valid = sel ? bus1.sink_valid : bus0.sink_valid;
    assign m_sink_last  = sel ? bus1.sink_last  : bus0.sink_last;
    assign m_sink_data  = sel ? bus1.sink_data  : bus0.sink_data;
    assign m_overflow   = sel ? bus1.overflow   : bus0.overflow;
    assign m_busy       = sel ? bus1.busy       : bus0.busy;

    multi_stream_sync #(.CH(CH), .DATA_W(DW), .DEPTH(DEPTH), .PAD_MODE(0), .PAD_VAL(PAD))
        dut0 (.clk(clk), .rst(rst), .io_if(bus0.slave));
    multi_stream_sync #(.CH(CH), .DATA_W(DW), .DEPTH(DEPTH), .PAD_MODE(1), .PAD_VAL(PAD))
        dut1 (.clk(clk), .rst(rst), .io_if(bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, mode %0d)", name, act, exp, cyc, sel);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rdy_rand) begin
            sink_ready[0] = $urandom_range(0, 3) != 0;
            sink_ready[1] = $urandom_range(0, 3) != 0;
        end else sink_ready = rdy_force;
    end

    // Monitor: peeks the head record every valid cycle, pops it on a lockstep fire.
    initial begin
        rec_t e;
        logic [15:0] dm;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (chk_sr) begin
                    check("src_ready_after_play", m_src_ready, ch_en);
                    chk_sr = 0;
                end
                if (|m_sink_valid) begin
                    if (sb.size() == 0) check("unexpected_beat", m_sink_valid, 0);
                    else begin
                        e = sb[0];
                        dm = {{8{e.v[1]}}, {8{e.v[0]}}};
                        if (await_first) begin
                            check("play_start_cycle", cyc, exp_first);
                            await_first = 0;
                        end
                        check("sink_valid", m_sink_valid, e.v);
                        check("sink_last", m_sink_last, e.l);
                        check("sink_data", m_sink_data & dm, e.d & dm);
                        check("busy_play", m_busy, 1);
                        if (&(~m_sink_valid | sink_ready)) begin
                            void'(sb.pop_front());
                            pops++;
                            if (e.fin) chk_sr = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic run_round(input logic [1:0] en, input int n0, input int n1, input bit h0,
                             input bit h1, input int dly1, input bit rnd);
        logic [7:0] d [2][16];
        int n[2], len[2], idx[2], tgt[2];
        int mx, t, last_cyc;
        bit h[2];
        logic [1:0] acc;
        rec_t r;
        n = '{n0, n1};
        h = '{h0, h1};
        mx = 0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) d[i][k] = rnd ? 8'($urandom) : 8'((i == 1 ? 8'hA0 : 8'h10) + k);
            len[i] = !en[i] ? 0 : (h[i] && n[i] <= DEPTH) ? n[i] : DEPTH;
            if (en[i] && !(h[i] && n[i] <= DEPTH)) ovf_model[i] = 1'b1;
            if (len[i] > mx) mx = len[i];
        end
        for (int i = 0; i < 2; i++) tgt[i] = sel ? (en[i] ? mx : 0) : len[i];
        for (int j = 0; j < mx; j++) begin
            for (int i = 0; i < 2; i++) begin
                r.v[i] = j < tgt[i];
                r.l[i] = j == tgt[i] - 1;
                r.d[i*8 +: 8] = j < len[i] ? d[i][j] : PAD;
            end
            r.fin = j == mx - 1;
            sb.push_back(r);
        end
        pops = 0;
        ch_en = en;
        idx = '{0, 0};
        t = 0;
        last_cyc = 0;
        while ((en[0] && idx[0] < len[0]) || (en[1] && idx[1] < len[1])) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                src_valid[i] = idx[i] < n[i] && (i == 0 || t >= dly1) && (!rnd || $urandom_range(0, 3) != 0);
                src_data[i*8 +: 8] = d[i][idx[i] % 16];
                src_last[i] = h[i] && idx[i] == n[i] - 1;
            end
            #1;
            for (int i = 0; i < 2; i++)
                if (!en[i] || idx[i] >= len[i]) check("src_ready_closed", m_src_ready[i], 0);
            acc = src_valid & m_src_ready;
            if (|acc) last_cyc = cyc;
            @(posedge clk);
            for (int i = 0; i < 2; i++) if (acc[i]) idx[i]++;
            t++;
            if (t > 300) begin
                check("capture_timeout", t, 0);
                break;
            end
        end
        for (int i = 0; i < 2; i++) if (en[i]) check("beats_accepted", idx[i], len[i]);
        exp_first = last_cyc + 2;
        await_first = 1;
        @(negedge clk);
        src_valid = 0;
        src_last = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("replay_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
        check("overflow", m_overflow, ovf_model);
        check("busy_idle", m_busy, 0);
    endtask

    task automatic wait_pops(input int k);
        int t = 0;
        while (pops < k && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (pops < k) check("pops_timeout", pops, k);
    endtask

    task automatic do_reset();
        rst = 0;
        ch_en = 2'b11;
        src_valid = 0;
        src_last = 0;
        sb.delete();
        await_first = 0;
        chk_sr = 0;
        ovf_model = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {m_src_ready, m_sink_valid, m_sink_last, m_overflow, m_busy, m_sink_data}, 0);
        @(negedge clk);
        rst = 1;
        #1;
        check("src_ready_after_reset", m_src_ready, 2'b11);
    endtask

    task automatic rand_round();
        logic [1:0] en;
        int n[2];
        bit h[2];
        en = 2'($urandom_range(1, 3));
        for (int i = 0; i < 2; i++) begin
            h[i] = $urandom_range(0, 4) != 0;
            n[i] = h[i] ? int'($urandom_range(1, 10)) : int'($urandom_range(8, 10));
        end
        run_round(en, n[0], n[1], h[0], h[1], int'($urandom_range(0, 4)), 1);
        wait_done();
    endtask

    initial begin
        sel = 0;
        do_reset();
        run_round(2'b11, 4, 2, 1, 1, 6, 0);
        wait_done();
        run_round(2'b11, 6, 5, 1, 1, 0, 1);
        wait_pops(2);
        @(posedge clk);
        rdy_force = 2'b01;
        repeat (3) @(posedge clk);
        rdy_force = 2'b11;
        wait_done();
        run_round(2'b11, 10, 3, 0, 1, 12, 0);
        wait_done();
        run_round(2'b11, 3, 2, 1, 1, 0, 1);
        wait_done();
        run_round(2'b01, 5, 4, 1, 1, 0, 1);
        wait_done();
        rdy_rand = 1;
        repeat (10) rand_round();
        rdy_rand = 0;
        run_round(2'b11, 5, 4, 1, 1, 0, 0);
        wait_pops(2);
        @(negedge clk);
        rst = 0;
        sb.delete();
        await_first = 0;
        chk_sr = 0;
        ovf_model = 0;
        @(posedge clk);
        #1;
        check("midplay_reset_outputs", {m_src_ready, m_sink_valid, m_sink_last, m_overflow, m_busy, m_sink_data}, 0);
        @(negedge clk);
        rst = 1;
        run_round(2'b11, 3, 6, 1, 1, 0, 1);
        wait_done();

        sel = 1;
        do_reset();
        run_round(2'b11, 4, 2, 1, 1, 6, 0);
        wait_done();
        run_round(2'b11, 10, 3, 0, 1, 0, 1);
        wait_done();
        run_round(2'b01, 5, 4, 1, 1, 0, 1);
        wait_done();
        rdy_rand = 1;
        repeat (10) rand_round();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
